lcd1602_driver: RTL

- Downstream consumer of the display FSM's two 128-bit text rows; drives an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus, write-only.
- Sequence: power-up wait, fixed init command list, then endless refresh of both lines from a per-frame snapshot of row1/row2.
- Character mapping: byte [127:120] is the leftmost column and [7:0] the rightmost; bytes are sent as ASCII unchanged.

---
 rtl/lcd1602_driver_if.sv | 18 +
 rtl/lcd1602_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_driver_if.sv
// ----------------------------------------------------------------------------
// lcd1602_driver_if
//   Write-only HD44780 8-bit parallel bus.
//   lcd_en   : enable strobe, the panel latches rs/data on its falling edge
//   lcd_rs   : 0 = command, 1 = character data
//   lcd_rw   : read/write select (always write)
//   lcd_data : 8-bit data bus
//   master = the driver, slave = the panel (or a bus monitor).
// ----------------------------------------------------------------------------
interface lcd1602_driver_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output lcd_en, output lcd_rs, output lcd_rw, output lcd_data);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd1602_driver.sv
// ----------------------------------------------------------------------------
// lcd1602_driver
//   Drives a 16x2 HD44780 panel: power-up wait, fixed init command list, then
//   an endless 34-step refresh of both lines from a per-frame snapshot.
//   Ports:
//     clk, nRst    : clock, asynchronous active-low reset
//     row1, row2   : 16 ASCII bytes each, [127:120] = leftmost column
//     lcd          : panel bus (lcd1602_driver_if.master)
//     init_done    : high from the first LINE1_ADDR step until reset
//     frame_done   : one-clk pulse on the last cycle of the final char step
// ----------------------------------------------------------------------------
module lcd1602_driver #(
    parameter int STEP_CYCLES   = 10000,
    parameter int POWERUP_STEPS = 40
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic [127:0]             row1,
    input  logic [127:0]             row2,
    lcd1602_driver_if.master         lcd,
    output logic                     init_done,
    output logic                     frame_done
);
    localparam int SCW     = $clog2(STEP_CYCLES);
    localparam int CNT_MAX = (POWERUP_STEPS > 16) ? POWERUP_STEPS : 16;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [SCW-1:0] SC_LAST = SCW'(STEP_CYCLES - 1);
    localparam logic [SCW-1:0] EN_LAST = SCW'(STEP_CYCLES / 2);
    localparam logic [CW-1:0]  PU_LAST = CW'(POWERUP_STEPS - 1);
    localparam logic [CW-1:0]  IN_LAST = CW'(4);
    localparam logic [CW-1:0]  CH_LAST = CW'(15);

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT, S_LINE1_ADDR, S_LINE1_CHAR, S_LINE2_ADDR, S_LINE2_CHAR
    } state_t;

    state_t           state_reg, state_next;
    logic [SCW-1:0]   sc_reg, sc_next;
    logic [CW-1:0]    cnt_reg, cnt_next;   // power-up step, init item or char index
    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;
    logic             en_reg, en_next;
    logic             bus_next;            // next step drives the bus
    logic             step_end;
    logic             init_done_reg, init_done_next;
    logic [127:0]     snap1_reg, snap2_reg;
    logic [7:0]       snap1_byte [16];
    logic [7:0]       snap2_byte [16];

    // Column gi of each snapshot; column 0 is the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign snap1_byte[gi] = snap1_reg[127 - 8*gi -: 8];
            assign snap2_byte[gi] = snap2_reg[127 - 8*gi -: 8];
        end
    endgenerate

    always_comb begin
        step_end   = (sc_reg == SC_LAST);
        sc_next    = step_end ? '0 : sc_reg + 1'b1;
        state_next = state_reg;
        cnt_next   = cnt_reg;

        if (step_end) begin
            unique case (state_reg)
                S_POWERUP: begin
                    if (cnt_reg == PU_LAST) begin
                        state_next = S_INIT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_INIT: begin
                    if (cnt_reg == IN_LAST) begin
                        state_next = S_LINE1_ADDR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_LINE1_ADDR: begin
                    state_next = S_LINE1_CHAR;
                    cnt_next   = '0;
                end
                S_LINE1_CHAR: begin
                    if (cnt_reg == CH_LAST) begin
                        state_next = S_LINE2_ADDR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_LINE2_ADDR: begin
                    state_next = S_LINE2_CHAR;
                    cnt_next   = '0;
                end
                S_LINE2_CHAR: begin
                    if (cnt_reg == CH_LAST) begin
                        state_next = S_LINE1_ADDR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = S_POWERUP;
                    cnt_next   = '0;
                end
            endcase
        end

        // Decode the byte of the step that follows, so rs/data are already
        // registered on that step's sc==0 cycle.
        bus_next  = 1'b1;
        rs_next   = 1'b0;
        data_next = 8'h00;
        unique case (state_next)
            S_POWERUP: bus_next = 1'b0;
            S_INIT: begin
                unique case (cnt_next[2:0])
                    3'd0:    data_next = 8'h38;
                    3'd1:    data_next = 8'h0C;
                    3'd2:    data_next = 8'h01;
                    3'd3:    bus_next  = 1'b0;   // clear-display settle time
                    default: data_next = 8'h06;
                endcase
            end
            S_LINE1_ADDR: data_next = 8'h80;
            S_LINE1_CHAR: begin
                rs_next   = 1'b1;
                data_next = snap1_byte[cnt_next[3:0]];
            end
            S_LINE2_ADDR: data_next = 8'hC0;
            S_LINE2_CHAR: begin
                rs_next   = 1'b1;
                data_next = snap2_byte[cnt_next[3:0]];
            end
            default: bus_next = 1'b0;
        endcase

        en_next        = bus_next && (sc_next != '0) && (sc_next <= EN_LAST);
        init_done_next = init_done_reg || (state_next == S_LINE1_ADDR);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg <= S_POWERUP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sc_reg        <= '0;
            cnt_reg       <= '0;
            rs_reg        <= 1'b0;
            data_reg      <= 8'h00;
            en_reg        <= 1'b0;
            init_done_reg <= 1'b0;
            snap1_reg     <= '0;
            snap2_reg     <= '0;
        end else begin
            sc_reg        <= sc_next;
            cnt_reg       <= cnt_next;
            en_reg        <= en_next;
            init_done_reg <= init_done_next;
            // Idle steps leave the bus holding the previous byte.
            if (step_end && bus_next) begin
                rs_reg   <= rs_next;
                data_reg <= data_next;
            end
            // Frame snapshot: rows are frozen for the whole 34-step frame.
            if (state_reg == S_LINE1_ADDR && sc_reg == '0) begin
                snap1_reg <= row1;
                snap2_reg <= row2;
            end
        end
    end

    assign frame_done   = (state_reg == S_LINE2_CHAR) && (cnt_reg == CH_LAST) && step_end;
    assign init_done    = init_done_reg;
    assign lcd.lcd_en   = en_reg;
    assign lcd.lcd_rs   = rs_reg;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_data = data_reg;
endmodule
